dca_matrix_store_packer: RTL

- Store-path counterpart of the matrix LSU load unpacker.
- Accepts LSU element rows of MATRIX_NUM_COL 32-bit elements and narrows each element to the instruction's element width (2^lsa_p3 bits).
- Packs the narrowed elements LSB-first into one memory row buffer with byte strobes, passing the transaction info alongside.
- Tracks rows per store instruction and flags the last row; sits between the LSU datapath and the AXI write-data formatter.

---
 rtl/dca_matrix_store_packer_pkg.sv | 45 ++++
 rtl/dca_matrix_store_narrow.sv | 49 ++++
 rtl/dca_matrix_store_packer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dca_matrix_store_packer_pkg.sv
// Shared types for the matrix store packer.
// Optional saturation: DCA_MATRIX_STORE_SATURATE_EN.
package dca_matrix_store_packer_pkg;

  localparam int BW_LSU_ELEMENT = 32;
  localparam int MAX_BW_MEMORY_SINGLE_DEFAULT = 32;
  localparam int BW_TXN_INFO = 8;

  localparam int BW_DCA_MATRIX_INFO_OPCODE = 4;
  localparam int BW_DCA_MATRIX_INFO_ADDR = 32;
  localparam int BW_DCA_MATRIX_INFO_STRIDE_LS3 = 16;
  localparam int BW_DCA_MATRIX_INFO_NUM_ROW_M1 = 4;
  localparam int BW_DCA_MATRIX_INFO_NUM_COL_M1 = 4;
  localparam int BW_DCA_MATRIX_INFO_LSA_P3 = 3;

  localparam logic [2:0] LSA_P3_W1 = 3'd0;
  localparam logic [2:0] LSA_P3_W2 = 3'd1;
  localparam logic [2:0] LSA_P3_W4 = 3'd2;
  localparam logic [2:0] LSA_P3_W8 = 3'd3;
  localparam logic [2:0] LSA_P3_W16 = 3'd4;
  localparam logic [2:0] LSA_P3_W32 = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN
  } state_t;

  // col_mask sits above this block; its width follows the matrix size
  typedef struct packed {
    logic [BW_DCA_MATRIX_INFO_LSA_P3-1:0] lsa_p3;
    logic is_float;
    logic is_signed;
    logic [BW_DCA_MATRIX_INFO_NUM_COL_M1-1:0] num_col_m1;
    logic [BW_DCA_MATRIX_INFO_NUM_ROW_M1-1:0] num_row_m1;
    logic [BW_DCA_MATRIX_INFO_STRIDE_LS3-1:0] stride_ls3;
    logic [BW_DCA_MATRIX_INFO_ADDR-1:0] addr;
    logic [BW_DCA_MATRIX_INFO_OPCODE-1:0] opcode;
  } dca_matrix_info_t;

  function automatic logic [2:0] lsa_clamp(input logic [2:0] v);
    return (v > LSA_P3_W32) ? LSA_P3_W32 : v;
  endfunction

endpackage

// File: rtl/dca_matrix_store_narrow.sv
// Narrows one 32-bit LSU element to 2^lsa_p3 bits.
// Saturation only with DCA_MATRIX_STORE_SATURATE_EN.
module dca_matrix_store_narrow
  import dca_matrix_store_packer_pkg::*;
(
  input  logic [BW_LSU_ELEMENT-1:0] elem,
  input  logic [2:0]                lsa_p3,
  input  logic                      is_signed,
  output logic [BW_LSU_ELEMENT-1:0] narrow
);

  logic [5:0]  w;
  logic [31:0] keep;

  assign w = 6'd1 << lsa_p3;
  assign keep = (lsa_p3 == LSA_P3_W32) ? '1
              : ((32'd1 << w) - 32'd1);

`ifdef DCA_MATRIX_STORE_SATURATE_EN
  logic [31:0] hi_s;
  logic [31:0] hi_u;
  logic [31:0] sat;
  logic        fit_s;
  logic        fit_u;

  // element fits if everything above the kept field is sign/zero fill
  always_comb begin
    hi_s = $unsigned($signed(elem) >>> (w - 6'd1));
    hi_u = elem >> w;
    fit_s = (hi_s == '0) || (hi_s == '1);
    fit_u = (hi_u == '0);
    sat = elem;
    if (lsa_p3 != LSA_P3_W32) begin
      if (is_signed && !fit_s)
        sat = elem[31] ? ~(keep >> 1) : (keep >> 1);
      else if (!is_signed && !fit_u)
        sat = keep;
    end
  end

  assign narrow = sat & keep;
`else
  logic unused_sign;

  assign unused_sign = is_signed;
  assign narrow = elem & keep;
`endif

endmodule

// File: rtl/dca_matrix_store_packer.sv
// Packs narrowed LSU element rows into memory rows with strobes.
// Optional saturation: DCA_MATRIX_STORE_SATURATE_EN.
module dca_matrix_store_packer
  import dca_matrix_store_packer_pkg::*;
#(
  parameter int LSU_PARA = 0,
  parameter int AXI_PARA = 32,
  parameter int MATRIX_SIZE_PARA = 4,
  localparam int MATRIX_NUM_COL = MATRIX_SIZE_PARA,
  localparam int BW_LSU_ELEMENT_ROW =
    MATRIX_NUM_COL * BW_LSU_ELEMENT,
  localparam int BW_MEMORY_ROW_BUFFER =
    MATRIX_NUM_COL * MAX_BW_MEMORY_SINGLE_DEFAULT,
  localparam int BW_RRESP_INFO =
    MATRIX_NUM_COL + $bits(dca_matrix_info_t)
) (
  input  logic                              clk,
  input  logic                              rstnn,
  input  logic                              inst_valid,
  output logic                              inst_ready,
  input  logic [BW_RRESP_INFO-1:0]          inst_info,
  input  logic                              elem_valid,
  output logic                              elem_ready,
  input  logic [BW_LSU_ELEMENT_ROW-1:0]     elem_row,
  input  logic [BW_TXN_INFO-1:0]            elem_txn,
  output logic                              wrow_valid,
  input  logic                              wrow_ready,
  output logic [BW_MEMORY_ROW_BUFFER-1:0]   wrow_data,
  output logic [BW_MEMORY_ROW_BUFFER/8-1:0] wrow_strb,
  output logic [BW_TXN_INFO-1:0]            wrow_txn,
  output logic                              wrow_last
);

  localparam int NC = MATRIX_NUM_COL;
  localparam int BW_STRB = BW_MEMORY_ROW_BUFFER / 8;
  localparam int BW_ROW = BW_DCA_MATRIX_INFO_NUM_ROW_M1;
  localparam int unused_para = LSU_PARA + AXI_PARA;

  state_t state;
  state_t state_nx;

  dca_matrix_info_t info_in;
  logic [NC-1:0]    mask_in;
  logic             unused_info;

  logic [NC-1:0]    col_mask_q;
  logic [2:0]       lsa_q;
  logic             sign_q;
  logic [BW_ROW-1:0] nrow_q;
  logic [BW_ROW-1:0] row_cnt;

  logic inst_fire;
  logic elem_fire;
  logic out_fire;
  logic last_row;

  logic [NC*32-1:0]               narrow_row;
  logic [5:0]                     w_bits;
  logic [3:0]                     byte_ones;
  logic [BW_MEMORY_ROW_BUFFER-1:0] pack_data;
  logic [BW_STRB-1:0]             pack_strb;

  assign {mask_in, info_in} = inst_info;
  assign unused_info = ^{info_in.is_float, info_in.num_col_m1,
                         info_in.stride_ls3, info_in.addr,
                         info_in.opcode};

  assign inst_fire = inst_valid & inst_ready;
  assign elem_fire = elem_valid & elem_ready;
  assign out_fire  = wrow_valid & wrow_ready;
  assign last_row  = (row_cnt == nrow_q);

  for (genvar g = 0; g < NC; g++) begin : g_col
    dca_matrix_store_narrow u_narrow (
      .elem      (elem_row[32*g +: 32]),
      .lsa_p3    (lsa_q),
      .is_signed (sign_q),
      .narrow    (narrow_row[32*g +: 32])
    );
  end

  assign w_bits = 6'd1 << lsa_q;
  assign byte_ones = (lsa_q == LSA_P3_W32) ? 4'hF
                   : (lsa_q == LSA_P3_W16) ? 4'h3
                   : 4'h1;

  // sub-byte widths share a strobe byte; any active column sets it
  always_comb begin
    pack_data = '0;
    pack_strb = '0;
    for (int i = 0; i < NC; i++) begin
      if (col_mask_q[i]) begin
        pack_data = pack_data
          | (BW_MEMORY_ROW_BUFFER'(narrow_row[32*i +: 32])
             << (32'(w_bits) * 32'(i)));
        pack_strb = pack_strb
          | (BW_STRB'(byte_ones)
             << ((32'(w_bits) * 32'(i)) >> 3));
      end
    end
  end

  always_comb begin
    state_nx = state;
    inst_ready = 1'b0;
    elem_ready = 1'b0;
    unique case (state)
      ST_IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        elem_ready = !wrow_valid | wrow_ready;
        if (elem_valid && elem_ready && last_row)
          state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wrow_valid && wrow_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state      <= ST_IDLE;
      row_cnt    <= '0;
      col_mask_q <= '0;
      lsa_q      <= '0;
      sign_q     <= 1'b0;
      nrow_q     <= '0;
      wrow_valid <= 1'b0;
      wrow_data  <= '0;
      wrow_strb  <= '0;
      wrow_txn   <= '0;
      wrow_last  <= 1'b0;
    end else begin
      state <= state_nx;
      if (inst_fire) begin
        col_mask_q <= mask_in;
        lsa_q      <= lsa_clamp(info_in.lsa_p3);
        sign_q     <= info_in.is_signed;
        nrow_q     <= info_in.num_row_m1;
        row_cnt    <= '0;
      end
      if (elem_fire) begin
        row_cnt    <= row_cnt + 1'b1;
        wrow_valid <= 1'b1;
        wrow_data  <= pack_data;
        wrow_strb  <= pack_strb;
        wrow_txn   <= elem_txn;
        wrow_last  <= last_row;
      end else if (out_fire) begin
        wrow_valid <= 1'b0;
      end
    end
  end

endmodule
